echo_responder: RTL and testbench

- Callee side of the echo test path, directly downstream of the test driver's `drive` rule.
- Accepts 32-bit words through an `enq` method (RDY/ENA handshake) into an internal FIFO.
- After an optional programmable delay, pops each word and calls the `heard` indication method, again with RDY/ENA.
- Counts completed echoes and flags protocol violations on the enqueue side.

---
 rtl/echo_pkg.sv | 17 +
 rtl/echo_fifo.sv | 62 ++++++
 rtl/echo_responder.sv | 110 +++++++++++
 tb/tb_echo_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
// Shared types and sizing helpers for the echo responder.
package echo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEND
    } echo_state_t;

    localparam int ECHO_DATA_W = 32;

    // Occupancy counter needs one extra bit to represent a full FIFO.
    function automatic int CNT_W(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/echo_fifo.sv
// Word FIFO for the echo path; drops writes while full and flags them.
module echo_fifo
    import echo_pkg::*;
#(
    parameter int DATA_W = ECHO_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              enq,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              deq,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head,
    output logic              overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = CNT_W(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push     = enq && !full;
    assign pop      = deq && !empty;
    assign overflow = enq && full;
    assign head     = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/echo_responder.sv
// Echo callee: queues enq words and replays them via heard after a delay.
module echo_responder
    import echo_pkg::*;
#(
    parameter int DATA_W = ECHO_DATA_W,
    parameter int DEPTH  = 4,
    parameter int DELAY  = 0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              enq__ENA,
    input  logic [DATA_W-1:0] enq_v,
    output logic              enq__RDY,
    input  logic              heard__RDY,
    output logic              heard__ENA,
    output logic [DATA_W-1:0] heard_v,
    output logic [31:0]       echo_count,
    output logic              enq_err
);

    localparam bit       NO_DELAY   = (DELAY == 0);
    localparam logic [7:0] TIMER_INIT =
        (DELAY > 0) ? 8'(DELAY - 1) : 8'd0;

    echo_state_t       state;
    echo_state_t       state_n;
    logic [7:0]        timer;
    logic [7:0]        timer_n;
    logic              full;
    logic              empty;
    logic              overflow;
    logic [DATA_W-1:0] head;

    echo_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .nRST     (nRST),
        .enq      (enq__ENA),
        .enq_data (enq_v),
        .deq      (heard__ENA),
        .full     (full),
        .empty    (empty),
        .head     (head),
        .overflow (overflow)
    );

    assign enq__RDY = !full;
    // Zero outside SEND so the sink never sees stale storage after reset.
    assign heard_v  = (state == SEND) ? head : '0;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
        end
    end

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        heard__ENA = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    if (NO_DELAY) begin
                        state_n = SEND;
                    end else begin
                        state_n = WAIT;
                        timer_n = TIMER_INIT;
                    end
                end
            end
            WAIT: begin
                if (timer == '0) begin
                    state_n = SEND;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            SEND: begin
                // A reset cycle must never complete a call.
                heard__ENA = heard__RDY && nRST;
                if (heard__ENA) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            echo_count <= '0;
            enq_err    <= 1'b0;
        end else begin
            if (heard__ENA) begin
                echo_count <= echo_count + 32'd1;
            end
            if (overflow) begin
                enq_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_echo_responder.sv
// Scoreboard bench for echo_responder (DELAY=0 main DUT, DELAY=3 latency DUT).
module tb_echo_responder;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        e_ena;
    logic [31:0] e_v;
    logic        e_rdy;
    logic        h_rdy;
    logic        h_ena;
    logic [31:0] h_v;
    logic [31:0] cnt0;
    logic        err0;

    logic        e3_ena;
    logic [31:0] e3_v;
    logic        e3_rdy;
    logic        h3_rdy;
    logic        h3_ena;
    logic [31:0] h3_v;
    logic [31:0] cnt3;
    logic        err3;

    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    int          mcount = 0;
    logic [31:0] q[$];

    always #5 CLK = ~CLK;

    echo_responder #(.DATA_W(32), .DEPTH(DEPTH), .DELAY(0)) dut0 (
        .CLK        (CLK),
        .nRST       (nRST),
        .enq__ENA   (e_ena),
        .enq_v      (e_v),
        .enq__RDY   (e_rdy),
        .heard__RDY (h_rdy),
        .heard__ENA (h_ena),
        .heard_v    (h_v),
        .echo_count (cnt0),
        .enq_err    (err0)
    );

    echo_responder #(.DATA_W(32), .DEPTH(DEPTH), .DELAY(3)) dut3 (
        .CLK        (CLK),
        .nRST       (nRST),
        .enq__ENA   (e3_ena),
        .enq_v      (e3_v),
        .enq__RDY   (e3_rdy),
        .heard__RDY (h3_rdy),
        .heard__ENA (h3_ena),
        .heard_v    (h3_v),
        .echo_count (cnt3),
        .enq_err    (err3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic enq1(input logic [31:0] w);
        e_ena = 1'b1;
        e_v   = w;
        tick();
        e_ena = 1'b0;
    endtask

    // Reference model: samples mid-cycle, when this cycle's inputs are settled.
    always @(negedge CLK) begin
        if (!nRST) begin
            check("rst_no_heard", 32'(h_ena), 32'd0);
            q.delete();
            mcount = 0;
        end else begin
            if (e_ena) begin
                check("enq_rdy", 32'(e_rdy), 32'(mcount != DEPTH));
                if (mcount < DEPTH) begin
                    q.push_back(e_v);
                    mcount++;
                end
            end
            if (h_ena) begin
                pulses++;
                if (q.size() == 0) begin
                    check("heard_unexpected", 32'd1, 32'd0);
                end else begin
                    check("heard_v", h_v, q.pop_front());
                    mcount--;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  pat0;
        logic [7:0]  pat3;
        logic [31:0] v3;
        logic [5:0]  hr_seq;
        logic        popped;
        int          p0;

        nRST   = 1'b0;
        e_ena  = 1'b0;
        e_v    = '0;
        e3_ena = 1'b0;
        e3_v   = '0;
        h_rdy  = 1'b1;
        h3_rdy = 1'b1;
        pat0   = '0;
        pat3   = '0;
        v3     = '0;
        repeat (2) tick();
        nRST = 1'b1;

        check("rst_heard_v", h_v, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("idle_rdy", 32'(e_rdy), 32'd1);
            check("idle_ena", 32'(h_ena), 32'd0);
            check("idle_cnt", cnt0, 32'd0);
            check("idle_err", 32'(err0), 32'd0);
            tick();
        end

        // Latency: DELAY=0 pulses at t+2, DELAY=3 at t+5.
        e_ena  = 1'b1;
        e_v    = 32'h0000_00A5;
        e3_ena = 1'b1;
        e3_v   = 32'h0000_0011;
        tick();
        e_ena  = 1'b0;
        e3_ena = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            pat0[i] = h_ena;
            pat3[i] = h3_ena;
            if (h3_ena) v3 = h3_v;
            tick();
        end
        check("lat_d0", 32'(pat0), 32'h02);
        check("lat_d3", 32'(pat3), 32'h10);
        check("d3_heard_v", v3, 32'h11);
        check("cnt_d0", cnt0, 32'd1);
        check("cnt_d3", cnt3, 32'd1);

        // Fill to DEPTH with the sink stalled, then overflow once.
        h_rdy = 1'b0;
        for (int w = 1; w <= 5; w++) begin
            enq1(32'(w));
            if (w == 4) check("full_rdy", 32'(e_rdy), 32'd0);
        end
        check("enq_err_set", 32'(err0), 32'd1);
        check("cnt_stall", cnt0, 32'd1);
        h_rdy = 1'b1;
        tick();
        check("rdy_after_pop", 32'(e_rdy), 32'd1);
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        check("drain", 32'(q.size()), 32'd0);
        repeat (2) tick();
        check("cnt_drain", cnt0, 32'd5);
        check("err_sticky", 32'(err0), 32'd1);

        // Stalled SEND must hold its word and fire exactly once.
        h_rdy = 1'b0;
        enq1(32'hDEAD_BEEF);
        repeat (2) tick();
        p0     = pulses;
        popped = 1'b0;
        hr_seq = 6'b100100;
        for (int i = 0; i < 6; i++) begin
            h_rdy = hr_seq[i];
            @(negedge CLK);
            if (!popped) check("hold_v", h_v, 32'hDEAD_BEEF);
            if (h_ena) popped = 1'b1;
            tick();
        end
        check("one_pulse", 32'(pulses - p0), 32'd1);
        check("cnt_hold", cnt0, 32'd6);

        // Reset with words queued discards them all.
        h_rdy = 1'b0;
        enq1(32'h100);
        enq1(32'h101);
        enq1(32'h102);
        tick();
        nRST  = 1'b0;
        h_rdy = 1'b1;
        tick();
        nRST = 1'b1;
        check("rst_cnt", cnt0, 32'd0);
        check("rst_err", 32'(err0), 32'd0);
        check("rst_rdy", 32'(e_rdy), 32'd1);
        p0 = pulses;
        repeat (5) tick();
        check("no_heard_post_rst", 32'(pulses - p0), 32'd0);
        enq1(32'h77);
        for (int i = 0; i < 10 && pulses == p0; i++) tick();
        check("post_rst_deliv", 32'(pulses - p0), 32'd1);
        tick();
        check("post_rst_cnt", cnt0, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
